// File: rtl/sprite_ram_arbiter_pkg.sv
// Shared types and defaults for the sprite RAM arbiter: read-owner encoding,
// fill sequencer state, default widths and the game-port wait-counter helper.
package sprite_ram_arbiter_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 16;
  localparam int DEFAULT_MAX_WAIT   = 4;

  // Wide enough for the largest legal MAX_WAIT (15).
  localparam int WAIT_CNT_WIDTH = 4;

  // Who issued the read that the SRAM is returning this cycle.
  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_VID  = 2'd1,
    OWNER_GL   = 2'd2
  } rd_owner_t;

  // Fill sequencer states.
  typedef enum logic [1:0] {
    FILL_IDLE = 2'd0,
    FILL_RUN  = 2'd1,
    FILL_DONE = 2'd2
  } fill_state_t;

  // Next value of the game-port wait counter: counts denied request cycles,
  // clears on grant or when the request drops, and saturates at max_wait.
  function automatic logic [WAIT_CNT_WIDTH-1:0] wait_next(
    input logic                      req,
    input logic                      gnt,
    input logic [WAIT_CNT_WIDTH-1:0] cnt,
    input logic [WAIT_CNT_WIDTH-1:0] max_wait
  );
    if (!req || gnt) begin
      return '0;
    end else if (cnt < max_wait) begin
      return cnt + 1'b1;
    end else begin
      return cnt;
    end
  endfunction

endpackage

// File: rtl/sprite_ram_arbiter_if.sv
// Single-port SRAM bus between the arbiter (master) and the SRAM (slave).
// Read data is registered in the SRAM and returns one cycle after the access.
interface sprite_ram_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
) ();

  logic                  en;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output en,
    output we,
    output addr,
    output wdata,
    input  rdata
  );

  modport slave (
    input  en,
    input  we,
    input  addr,
    input  wdata,
    output rdata
  );

endinterface

// File: rtl/sprite_ram_arbiter_fill_sequencer.sv
// Fill engine: writes fill_value over fill_len consecutive addresses starting
// at fill_base (wrapping at the top of the address space), one word per cycle
// in which it wins arbitration. Requests the memory only while running.
module fill_sequencer
  import sprite_ram_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH-1:0] len,
  input  logic [DATA_WIDTH-1:0] value,
  input  logic                  gnt,
  output logic                  req,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  busy,
  output logic                  done
);

  fill_state_t           state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] remaining;
  logic [DATA_WIDTH-1:0] value_q;

  logic last_write;
  assign last_write = gnt && (remaining == ADDR_WIDTH'(1));

  // Control FSM with registered busy/done outputs; start is only honoured in IDLE.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FILL_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        FILL_IDLE: begin
          if (start) begin
            if (len == '0) begin
              state <= FILL_DONE;
              done  <= 1'b1;
            end else begin
              state <= FILL_RUN;
              busy  <= 1'b1;
            end
          end
        end
        FILL_RUN: begin
          if (last_write) begin
            state <= FILL_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        FILL_DONE: begin
          state <= FILL_IDLE;
        end
        default: begin
          state <= FILL_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Address, count and value registers: loaded on an accepted start, stepped
  // on every granted fill write.
  // NOTE: these datapath registers carry no reset; they are only observed
  // while busy, and busy is only set in the same edge that loads them.
  always_ff @(posedge clk) begin
    if (state == FILL_IDLE && start) begin
      cur_addr  <= base;
      remaining <= len;
      value_q   <= value;
    end else if (state == FILL_RUN && gnt) begin
      cur_addr  <= cur_addr + 1'b1;
      remaining <= remaining - 1'b1;
    end
  end

  // busy is exactly "state == RUN", so the request comes straight off a flop.
  assign req  = busy;
  assign addr = cur_addr;
  assign data = value_q;

endmodule

// File: rtl/sprite_ram_arbiter.sv
// Arbiter sharing one single-port sprite/tile SRAM between video fetch,
// the game-logic port and the fill engine. Priority is video > game > fill,
// except that a game request denied MAX_WAIT cycles in a row beats video.
// Grants are combinational from request inputs and registered state only;
// mem_rdata never feeds the memory drive.
module sprite_ram_arbiter
  import sprite_ram_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int MAX_WAIT   = DEFAULT_MAX_WAIT
) (
  input  logic                  clk,
  input  logic                  reset,

  // Video fetch (read only)
  input  logic                  vid_req,
  input  logic [ADDR_WIDTH-1:0] vid_addr,
  output logic                  vid_valid,
  output logic [DATA_WIDTH-1:0] vid_data,
  output logic                  vid_miss,

  // Game-logic port
  input  logic                  gl_req,
  input  logic                  gl_we,
  input  logic [ADDR_WIDTH-1:0] gl_addr,
  input  logic [DATA_WIDTH-1:0] gl_wdata,
  output logic                  gl_gnt,
  output logic                  gl_rvalid,
  output logic [DATA_WIDTH-1:0] gl_rdata,

  // Fill engine control
  input  logic                  fill_start,
  input  logic [ADDR_WIDTH-1:0] fill_base,
  input  logic [ADDR_WIDTH-1:0] fill_len,
  input  logic [DATA_WIDTH-1:0] fill_value,
  output logic                  fill_busy,
  output logic                  fill_done,

  // SRAM bus
  sprite_ram_arbiter_if.master  mem
);

  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
    $error("sprite_ram_arbiter: MAX_WAIT must be in 1..15");
  end

  localparam logic [WAIT_CNT_WIDTH-1:0] MAX_WAIT_CNT = WAIT_CNT_WIDTH'(MAX_WAIT);

  logic [WAIT_CNT_WIDTH-1:0] wait_cnt;
  rd_owner_t                 rd_owner;

  logic                      override;
  logic                      vid_gnt;
  logic                      fill_gnt;

  logic                      fill_req;
  logic [ADDR_WIDTH-1:0]     fill_addr;
  logic [DATA_WIDTH-1:0]     fill_data;

  fill_sequencer #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fill (
    .clk   (clk),
    .reset (reset),
    .start (fill_start),
    .base  (fill_base),
    .len   (fill_len),
    .value (fill_value),
    .gnt   (fill_gnt),
    .req   (fill_req),
    .addr  (fill_addr),
    .data  (fill_data),
    .busy  (fill_busy),
    .done  (fill_done)
  );

  // Starved game port: it has been denied MAX_WAIT cycles and still asks.
  assign override = gl_req && (wait_cnt == MAX_WAIT_CNT);

  // Per-cycle arbitration. Nothing is granted while reset is held, so a
  // reset mid-fill stops writes in the very cycle it is asserted.
  // NOTE: every output of a combinational block gets a default first so no
  // path through the if/else chain can infer a latch.
  always_comb begin
    vid_gnt  = 1'b0;
    gl_gnt   = 1'b0;
    fill_gnt = 1'b0;
    if (!reset) begin
      if (override) begin
        gl_gnt = 1'b1;
      end else if (vid_req) begin
        vid_gnt = 1'b1;
      end else if (gl_req) begin
        gl_gnt = 1'b1;
      end else if (fill_req) begin
        fill_gnt = 1'b1;
      end
    end
  end

  // Drive the SRAM from the winner; an idle bus is held at all zeros.
  always_comb begin
    mem.en    = 1'b0;
    mem.we    = 1'b0;
    mem.addr  = '0;
    mem.wdata = '0;
    if (vid_gnt) begin
      mem.en    = 1'b1;
      mem.addr  = vid_addr;
    end else if (gl_gnt) begin
      mem.en    = 1'b1;
      mem.we    = gl_we;
      mem.addr  = gl_addr;
      mem.wdata = gl_wdata;
    end else if (fill_gnt) begin
      mem.en    = 1'b1;
      mem.we    = 1'b1;
      mem.addr  = fill_addr;
      mem.wdata = fill_data;
    end
  end

  // Wait counter, video miss pulse and read-owner tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
      vid_miss <= 1'b0;
      rd_owner <= OWNER_NONE;
    end else begin
      wait_cnt <= wait_next(gl_req, gl_gnt, wait_cnt, MAX_WAIT_CNT);
      vid_miss <= vid_req && !vid_gnt;
      if (vid_gnt) begin
        rd_owner <= OWNER_VID;
      end else if (gl_gnt && !gl_we) begin
        rd_owner <= OWNER_GL;
      end else begin
        rd_owner <= OWNER_NONE;
      end
    end
  end

  // Both read ports see the SRAM output; the owner decides whose valid fires.
  assign vid_valid = (rd_owner == OWNER_VID);
  assign gl_rvalid = (rd_owner == OWNER_GL);
  assign vid_data  = mem.rdata;
  assign gl_rdata  = mem.rdata;

endmodule

// File: tb/tb_sprite_ram_arbiter.sv
// Directed bench for sprite_ram_arbiter with a behavioural write-first,
// registered-read SRAM model on the memory bus.
module tb_sprite_ram_arbiter;

  localparam int DW = 8;
  localparam int AW = 16;

  logic          clk;
  logic          reset;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_valid;
  logic [DW-1:0] vid_data;
  logic          vid_miss;
  logic          gl_req;
  logic          gl_we;
  logic [AW-1:0] gl_addr;
  logic [DW-1:0] gl_wdata;
  logic          gl_gnt;
  logic          gl_rvalid;
  logic [DW-1:0] gl_rdata;
  logic          fill_start;
  logic [AW-1:0] fill_base;
  logic [AW-1:0] fill_len;
  logic [DW-1:0] fill_value;
  logic          fill_busy;
  logic          fill_done;

  int vectors;
  int miscompares;

  sprite_ram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sprite_ram_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MAX_WAIT   (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_valid  (vid_valid),
    .vid_data   (vid_data),
    .vid_miss   (vid_miss),
    .gl_req     (gl_req),
    .gl_we      (gl_we),
    .gl_addr    (gl_addr),
    .gl_wdata   (gl_wdata),
    .gl_gnt     (gl_gnt),
    .gl_rvalid  (gl_rvalid),
    .gl_rdata   (gl_rdata),
    .fill_start (fill_start),
    .fill_base  (fill_base),
    .fill_len   (fill_len),
    .fill_value (fill_value),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .mem        (bus)
  );

  // SRAM model: single port, write-first, registered read.
  logic [DW-1:0] sram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.en) begin
      if (bus.we) begin
        sram[bus.addr] <= bus.wdata;
        bus.rdata      <= bus.wdata;
      end else begin
        bus.rdata <= sram[bus.addr];
      end
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow a settle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    vid_req     = 1'b0;
    vid_addr    = '0;
    gl_req      = 1'b0;
    gl_we       = 1'b0;
    gl_addr     = '0;
    gl_wdata    = '0;
    fill_start  = 1'b0;
    fill_base   = '0;
    fill_len    = '0;
    fill_value  = '0;

    // ---------------- reset state ----------------
    next_cycle();
    next_cycle();
    settle();
    check("rst_vid_valid", vid_valid, 0);
    check("rst_vid_miss",  vid_miss,  0);
    check("rst_gl_rvalid", gl_rvalid, 0);
    check("rst_fill_busy", fill_busy, 0);
    check("rst_fill_done", fill_done, 0);
    check("rst_mem_en",    bus.en,    0);
    reset = 1'b0;
    settle();
    check("idle_mem_en",   bus.en,    0);
    check("idle_mem_addr", bus.addr,  0);

    // ---------------- preload through the game port ----------------
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      gl_req   = 1'b1;
      gl_we    = 1'b1;
      gl_addr  = 16'h0100 + 16'(i);
      gl_wdata = 8'hA0 + 8'(i);
      settle();
      check("pre_gnt",  gl_gnt,    1);
      check("pre_we",   bus.we,    1);
      check("pre_addr", bus.addr,  16'h0100 + 16'(i));
      check("pre_data", bus.wdata, 8'hA0 + 8'(i));
      next_cycle();
    end
    gl_addr  = 16'h0010;
    gl_wdata = 8'h3C;
    settle();
    check("pre10_gnt", gl_gnt, 1);
    next_cycle();
    gl_req = 1'b0;
    gl_we  = 1'b0;
    settle();
    check("write_no_rvalid", gl_rvalid, 0);
    check("idle_gnt",        gl_gnt,    0);
    next_cycle();

    // ---------------- 1: video streaming ----------------
    vid_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vid_addr = 16'h0100 + 16'(i);
      settle();
      check("vs_mem_en",   bus.en,   1);
      check("vs_mem_we",   bus.we,   0);
      check("vs_mem_addr", bus.addr, 16'h0100 + 16'(i));
      if (i > 0) begin
        check("vs_valid", vid_valid, 1);
        check("vs_data",  vid_data,  8'hA0 + 8'(i - 1));
        check("vs_miss",  vid_miss,  0);
      end
      next_cycle();
    end
    vid_req = 1'b0;
    settle();
    check("vs_valid_last", vid_valid, 1);
    check("vs_data_last",  vid_data,  8'hA3);
    check("vs_miss_last",  vid_miss,  0);
    next_cycle();
    check("vs_valid_off",  vid_valid, 0);

    // ---------------- 2: starvation override ----------------
    vid_req  = 1'b1;
    vid_addr = 16'h0100;
    gl_req   = 1'b1;
    gl_we    = 1'b0;
    gl_addr  = 16'h0010;
    for (int c = 1; c <= 5; c++) begin
      settle();
      check("sv_gl_gnt",   gl_gnt,   (c == 5) ? 1 : 0);
      check("sv_mem_addr", bus.addr, (c == 5) ? 16'h0010 : 16'h0100);
      if (c >= 2) begin
        check("sv_vid_valid", vid_valid, 1);
        check("sv_vid_data",  vid_data,  8'hA0);
        check("sv_vid_miss",  vid_miss,  0);
        check("sv_gl_rvalid", gl_rvalid, 0);
      end
      next_cycle();
    end
    vid_req = 1'b0;
    gl_req  = 1'b0;
    settle();
    check("sv_miss",      vid_miss,  1);
    check("sv_vid_inval", vid_valid, 0);
    check("sv_rvalid",    gl_rvalid, 1);
    check("sv_rdata",     gl_rdata,  8'h3C);
    next_cycle();
    check("sv_miss_off",   vid_miss,  0);
    check("sv_rvalid_off", gl_rvalid, 0);

    // ---------------- 3: fill with wrap ----------------
    fill_base  = 16'hFFFE;
    fill_len   = 16'd4;
    fill_value = 8'h55;
    fill_start = 1'b1;
    settle();
    check("fw_start_mem_en", bus.en, 0);
    next_cycle();
    fill_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("fw_busy",  fill_busy, 1);
      check("fw_done",  fill_done, 0);
      check("fw_we",    bus.we,    1);
      check("fw_addr",  bus.addr,  16'(32'hFFFE + i));
      check("fw_wdata", bus.wdata, 8'h55);
      next_cycle();
    end
    settle();
    check("fw_done_pulse", fill_done, 1);
    check("fw_busy_off",   fill_busy, 0);
    check("fw_mem_idle",   bus.en,    0);
    next_cycle();
    check("fw_done_off",   fill_done, 0);
    vid_req  = 1'b1;
    vid_addr = 16'h0000;
    next_cycle();
    vid_addr = 16'hFFFF;
    settle();
    check("fw_rd_0000", vid_data, 8'h55);
    next_cycle();
    vid_req = 1'b0;
    settle();
    check("fw_rd_ffff", vid_data, 8'h55);
    next_cycle();

    // ---------------- 4: preempted fill ----------------
    fill_base  = 16'h0200;
    fill_len   = 16'd3;
    fill_value = 8'h77;
    fill_start = 1'b1;
    vid_addr   = 16'h0100;
    next_cycle();
    fill_start = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      vid_req = (j % 2 == 1);
      settle();
      check("pf_busy", fill_busy, 1);
      check("pf_done", fill_done, 0);
      if (j % 2 == 1) begin
        check("pf_vid_we",   bus.we,   0);
        check("pf_vid_addr", bus.addr, 16'h0100);
      end else begin
        check("pf_fill_we",   bus.we,    1);
        check("pf_fill_addr", bus.addr,  16'h0200 + 16'(j / 2 - 1));
        check("pf_fill_data", bus.wdata, 8'h77);
      end
      next_cycle();
    end
    vid_req = 1'b0;
    settle();
    check("pf_done_pulse", fill_done, 1);
    check("pf_busy_off",   fill_busy, 0);
    next_cycle();
    check("pf_done_off",   fill_done, 0);

    // ---------------- 5a: zero-length fill ----------------
    fill_base  = 16'h0300;
    fill_len   = 16'd0;
    fill_value = 8'hEE;
    fill_start = 1'b1;
    settle();
    check("z_start_we", bus.we, 0);
    next_cycle();
    fill_start = 1'b0;
    settle();
    check("z_done", fill_done, 1);
    check("z_busy", fill_busy, 0);
    check("z_we",   bus.we,    0);
    next_cycle();
    check("z_done_off", fill_done, 0);

    // ---------------- 5b: restart attempts during RUN and DONE ----------------
    fill_base  = 16'h0300;
    fill_len   = 16'd2;
    fill_value = 8'h11;
    fill_start = 1'b1;
    next_cycle();
    fill_base  = 16'h0400;
    fill_len   = 16'd5;
    fill_value = 8'h22;
    settle();
    check("rs_addr0", bus.addr,  16'h0300);
    check("rs_data0", bus.wdata, 8'h11);
    next_cycle();
    fill_start = 1'b0;
    settle();
    check("rs_addr1", bus.addr,  16'h0301);
    check("rs_data1", bus.wdata, 8'h11);
    next_cycle();
    fill_start = 1'b1;
    settle();
    check("rs_done",  fill_done, 1);
    next_cycle();
    fill_start = 1'b0;
    settle();
    check("rs_busy_after", fill_busy, 0);
    check("rs_done_after", fill_done, 0);
    check("rs_mem_idle",   bus.en,    0);
    next_cycle();

    // ---------------- 6: reset mid-fill ----------------
    fill_base  = 16'h0500;
    fill_len   = 16'd8;
    fill_value = 8'h99;
    fill_start = 1'b1;
    next_cycle();
    fill_start = 1'b0;
    settle();
    check("rm_addr0", bus.addr, 16'h0500);
    next_cycle();
    settle();
    check("rm_addr1", bus.addr, 16'h0501);
    next_cycle();
    reset = 1'b1;
    settle();
    check("rm_rst_mem_en", bus.en, 0);
    next_cycle();
    reset = 1'b0;
    settle();
    check("rm_busy",   fill_busy, 0);
    check("rm_done",   fill_done, 0);
    check("rm_mem_en", bus.en,    0);
    next_cycle();
    check("rm_done_late", fill_done, 0);
    check("rm_mem_late",  bus.en,    0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
